// File: rtl/mem_dump.sv
// Walks a word range through the data BRAM debug port and streams each word as four bytes, LSB first.
// Optional trailing checksum byte is enabled with `define MEM_DUMP_CHECKSUM_EN.
module mem_dump #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [8:0]            word_cnt,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  cpu_stall,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
`ifdef MEM_DUMP_CHECKSUM_EN
    CSUM  = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [8:0]            words_left;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [1:0]            byte_idx;
  logic                  handshake;
  logic                  last_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]            checksum;
`endif

  assign handshake = tx_valid & tx_ready;
  assign last_byte = (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = (word_cnt == 9'd0) ? DONE : FETCH;
      FETCH: next_state = SEND;
      SEND: begin
        if (tx_ready && last_byte) begin
          if (words_left == 9'd1)
`ifdef MEM_DUMP_CHECKSUM_EN
            next_state = CSUM;
`else
            next_state = DONE;
`endif
          else
            next_state = FETCH;
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      CSUM:  if (tx_ready) next_state = DONE;
`endif
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: the byte lane is always shift_reg[7:0], so each accepted byte shifts the word down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      words_left <= '0;
      shift_reg  <= '0;
      byte_idx   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= start_addr & ~ADDR_WIDTH'(3);
            words_left <= word_cnt;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum   <= '0;
`endif
          end
        end
        FETCH: begin
          shift_reg <= debug_data;
          byte_idx  <= 2'd0;
        end
        SEND: begin
          if (handshake) begin
            shift_reg <= shift_reg >> 8;
            byte_idx  <= byte_idx + 2'd1;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum  <= checksum + shift_reg[7:0];
`endif
            if (last_byte && (words_left != 9'd1)) begin
              words_left <= words_left - 9'd1;
              cur_addr   <= cur_addr + ADDR_WIDTH'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state and held registers only, never from tx_ready.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    debug_addr = '0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    if (state != IDLE) debug_addr = cur_addr;
    case (state)
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_reg[7:0];
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = checksum;
      end
`endif
      default: ;
    endcase
  end

  assign cpu_stall = busy;

endmodule

// File: tb/tb_mem_dump.sv
// Directed self-checking bench for mem_dump; covers both the plain and the checksum build.
module tb_mem_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [8:0]  word_cnt = '0;
  logic [9:0]  debug_addr;
  logic [31:0] debug_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        cpu_stall;
  logic        done;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign debug_data = mem[debug_addr[9:2]];

  mem_dump #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_cnt(word_cnt), .debug_addr(debug_addr), .debug_data(debug_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .cpu_stall(cpu_stall), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start so that it is captured at the next edge; returns mid-cycle in FETCH/DONE.
  task automatic applyStimulus(input logic [9:0] addr, input logic [8:0] cnt);
    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    word_cnt   = cnt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic receiveByte(input string tag, input int max_wait, input logic [7:0] exp);
    int waited = 0;
    @(negedge clk);
    while (!(tx_valid && tx_ready) && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_hs"}, {31'd0, tx_valid & tx_ready}, 32'd1);
    checkOutput(tag, {24'd0, tx_data}, {24'd0, exp});
  endtask

  task automatic checkDone(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_valid_in_done"}, {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done_fall"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic dumpBasic(input string tag);
    logic [7:0] exp_bytes [0:11];
    exp_bytes = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
                  8'h0C, 8'h00, 8'h00, 8'h00};
    tx_ready = 1'b1;
    applyStimulus(10'h000, 9'd3);
    checkOutput({tag, "_fetch_busy"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, "_fetch_valid"}, {31'd0, tx_valid}, 32'd0);
    checkOutput({tag, "_fetch_addr"}, {22'd0, debug_addr}, 32'h000);
    for (int i = 0; i < 12; i++)
      receiveByte($sformatf("%s_b%0d", tag, i), (i % 4 == 0 && i != 0) ? 1 : 0, exp_bytes[i]);
`ifdef MEM_DUMP_CHECKSUM_EN
    receiveByte({tag, "_csum"}, 0, 8'h1E);
`endif
    checkDone(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_0008;
    mem[1]   = 32'h0000_000A;
    mem[2]   = 32'h0000_000C;
    mem[4]   = 32'hDEAD_BEEF;
    mem[255] = 32'h1122_3344;

    #1;
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'h00);
    checkOutput("rst_debug_addr", {22'd0, debug_addr}, 32'h000);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic dump");
    dumpBasic("basic");

    $display("[TB] backpressure");
    tx_ready = 1'b0;
    applyStimulus(10'h010, 9'd1);
    checkOutput("bp_fetch_addr", {22'd0, debug_addr}, 32'h010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold_valid%0d", i), {31'd0, tx_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_data%0d", i), {24'd0, tx_data}, 32'hEF);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    receiveByte("bp_b0", 0, 8'hEF);
    receiveByte("bp_b1", 0, 8'hBE);
    receiveByte("bp_b2", 0, 8'hAD);
    receiveByte("bp_b3", 0, 8'hDE);
`ifdef MEM_DUMP_CHECKSUM_EN
    receiveByte("bp_csum", 0, 8'h38);
`endif
    checkDone("bp");

    $display("[TB] wrap and alignment");
    applyStimulus(10'h3FE, 9'd2);
    checkOutput("wrap_addr0", {22'd0, debug_addr}, 32'h3FC);
    receiveByte("wrap_b0", 0, 8'h44);
    receiveByte("wrap_b1", 0, 8'h33);
    receiveByte("wrap_b2", 0, 8'h22);
    receiveByte("wrap_b3", 0, 8'h11);
    @(negedge clk);
    checkOutput("wrap_addr1", {22'd0, debug_addr}, 32'h000);
    checkOutput("wrap_fetch_valid", {31'd0, tx_valid}, 32'd0);
    receiveByte("wrap_b4", 0, 8'h08);
    receiveByte("wrap_b5", 0, 8'h00);
    receiveByte("wrap_b6", 0, 8'h00);
    receiveByte("wrap_b7", 0, 8'h00);
`ifdef MEM_DUMP_CHECKSUM_EN
    receiveByte("wrap_csum", 0, 8'hB2);
`endif
    checkDone("wrap");

    $display("[TB] zero word count");
    applyStimulus(10'h020, 9'd0);
    checkOutput("zero_done", {31'd0, done}, 32'd1);
    checkOutput("zero_busy", {31'd0, busy}, 32'd1);
    checkOutput("zero_stall", {31'd0, cpu_stall}, 32'd1);
    checkOutput("zero_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    checkOutput("zero_done_fall", {31'd0, done}, 32'd0);
    checkOutput("zero_busy_fall", {31'd0, busy}, 32'd0);
    checkOutput("zero_valid_after", {31'd0, tx_valid}, 32'd0);

    $display("[TB] start while busy");
    tx_ready = 1'b0;
    applyStimulus(10'h008, 9'd1);
    @(negedge clk);
    start      = 1'b1;
    start_addr = 10'h010;
    word_cnt   = 9'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_start_data", {24'd0, tx_data}, 32'h0C);
    checkOutput("busy_start_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    receiveByte("busy_b0", 0, 8'h0C);
    receiveByte("busy_b1", 0, 8'h00);
    receiveByte("busy_b2", 0, 8'h00);
    receiveByte("busy_b3", 0, 8'h00);
`ifdef MEM_DUMP_CHECKSUM_EN
    receiveByte("busy_csum", 0, 8'h0C);
`endif
    checkDone("busy");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_idle_valid%0d", i), {31'd0, tx_valid}, 32'd0);
      checkOutput($sformatf("busy_idle_busy%0d", i), {31'd0, busy}, 32'd0);
    end

    $display("[TB] reset mid-dump");
    applyStimulus(10'h000, 9'd3);
    receiveByte("rmid_b0", 1, 8'h08);
    receiveByte("rmid_b1", 0, 8'h00);
    receiveByte("rmid_b2", 0, 8'h00);
    receiveByte("rmid_b3", 0, 8'h00);
    receiveByte("rmid_b4", 1, 8'h0A);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rmid_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rmid_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rmid_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rmid_post_done%0d", i), {31'd0, done}, 32'd0);
      checkOutput($sformatf("rmid_post_valid%0d", i), {31'd0, tx_valid}, 32'd0);
    end
    dumpBasic("redo");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
